// File: rtl/jmp_seq_unit.sv
// jmp_seq_unit
//   Branch sequencer that sits beside the PC register. It accepts a jump op,
//   assembles a multi-byte target from the data bus (most significant byte
//   first), evaluates a condition on the flags latched with the op, and
//   issues a single-cycle registered PC load. Modes: absolute, PC-relative,
//   call (pushes the current PC) and return (pops the return-address stack).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   op_valid           start strobe, accepted only while idle
//   op[5:0]            [3:0] condition select, [5:4] mode (abs/rel/call/ret)
//   databus            address byte, shifted in on byte_we while collecting
//   byte_we            byte write strobe
//   pcin               current PC (sampled in the execute cycle)
//   zflag/cflag/oflag/sflag  ALU flags, latched together with op
//   busy               high whenever the unit is not idle
//   pc_load            one-cycle PC load strobe
//   pc_out             branch target, zero whenever pc_load is low
//   depth              return-address stack occupancy
//   stk_overflow       sticky: call attempted with a full stack
//   stk_underflow      sticky: return attempted with an empty stack
module jmp_seq_unit #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               op_valid,
    input  logic [5:0]                         op,
    input  logic [DATA_W-1:0]                  databus,
    input  logic                               byte_we,
    input  logic [ADDR_W-1:0]                  pcin,
    input  logic                               zflag,
    input  logic                               cflag,
    input  logic                               oflag,
    input  logic                               sflag,
    output logic                               busy,
    output logic                               pc_load,
    output logic [ADDR_W-1:0]                  pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stk_overflow,
    output logic                               stk_underflow
);

    localparam int NBYTES  = ADDR_W / DATA_W;
    localparam int CNT_W   = $clog2(NBYTES + 1);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [DEPTH_W-1:0] FULL      = DEPTH_W'(STACK_DEPTH);

    localparam logic [1:0] MODE_ABS  = 2'b00;
    localparam logic [1:0] MODE_REL  = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;
    localparam logic [1:0] MODE_RET  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EXEC    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [5:0]        op_q;
    logic              z_q, c_q, o_q, s_q;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] stk [STACK_DEPTH];

    logic [1:0]        mode;
    logic              taken;
    logic              stk_full;
    logic              stk_empty;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    function automatic logic cond_eval(input logic [3:0] code,
                                       input logic z, input logic c,
                                       input logic o, input logic s);
        logic r;
        r = 1'b0;
        case (code)
            4'd0:    r = 1'b1;
            4'd1:    r = z;
            4'd2:    r = !z;
            4'd3:    r = c;
            4'd4:    r = c | z;
            4'd5:    r = !(c | z);
            4'd6:    r = !c;
            4'd7:    r = o ^ s;
            4'd8:    r = (o ^ s) | z;
            4'd9:    r = !(o ^ s) & !z;
            4'd10:   r = !(o ^ s);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign mode      = op_q[5:4];
    assign taken     = cond_eval(op_q[3:0], z_q, c_q, o_q, s_q);
    assign stk_full  = (depth == FULL);
    assign stk_empty = (depth == '0);
    // Push slot is the current occupancy; top of stack is one below it.
    assign push_idx  = depth[IDX_W-1:0];
    assign pop_idx   = push_idx - IDX_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (op_valid) state_nxt = (op[5:4] == MODE_RET) ? EXEC : COLLECT;
            end
            COLLECT: begin
                if (byte_we && cnt == LAST_BYTE) state_nxt = EXEC;
            end
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Op latch, address assembly, PC load and stack control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            z_q           <= 1'b0;
            c_q           <= 1'b0;
            o_q           <= 1'b0;
            s_q           <= 1'b0;
            addr          <= '0;
            cnt           <= '0;
            depth         <= '0;
            pc_load       <= 1'b0;
            pc_out        <= '0;
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            pc_out  <= '0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q <= op;
                        z_q  <= zflag;
                        c_q  <= cflag;
                        o_q  <= oflag;
                        s_q  <= sflag;
                        if (op[5:4] != MODE_RET) begin
                            addr <= '0;
                            cnt  <= '0;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_we) begin
                        // Shift left so the first byte ends up most significant.
                        addr <= (addr << DATA_W) | ADDR_W'(databus);
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                EXEC: begin
                    if (taken) begin
                        case (mode)
                            MODE_ABS: begin
                                pc_load <= 1'b1;
                                pc_out  <= addr;
                            end
                            MODE_REL: begin
                                pc_load <= 1'b1;
                                pc_out  <= pcin + addr;
                            end
                            MODE_CALL: begin
                                if (stk_full) begin
                                    stk_overflow <= 1'b1;
                                end else begin
                                    pc_load <= 1'b1;
                                    pc_out  <= addr;
                                    depth   <= depth + DEPTH_W'(1);
                                end
                            end
                            default: begin
                                if (stk_empty) begin
                                    stk_underflow <= 1'b1;
                                end else begin
                                    pc_load <= 1'b1;
                                    pc_out  <= stk[pop_idx];
                                    depth   <= depth - DEPTH_W'(1);
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Return-address storage; occupancy is tracked by depth, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == EXEC && taken && mode == MODE_CALL && !stk_full)
            stk[push_idx] <= pcin;
    end

endmodule

// File: tb/tb_jmp_seq_unit.sv
module tb_jmp_seq_unit;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 16;
    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               op_valid;
    logic [5:0]         op;
    logic [DATA_W-1:0]  databus;
    logic               byte_we;
    logic [ADDR_W-1:0]  pcin;
    logic               zflag, cflag, oflag, sflag;
    logic               busy;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_out;
    logic [DEPTH_W-1:0] depth;
    logic               stk_overflow;
    logic               stk_underflow;

    int n_vec = 0;
    int n_err = 0;

    jmp_seq_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .databus(databus), .byte_we(byte_we), .pcin(pcin),
        .zflag(zflag), .cflag(cflag), .oflag(oflag), .sflag(sflag),
        .busy(busy), .pc_load(pc_load), .pc_out(pc_out), .depth(depth),
        .stk_overflow(stk_overflow), .stk_underflow(stk_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] pc;
        logic [3:0]  fl;       // {z,c,o,s} at op_valid
        logic [3:0]  fl_late;  // {z,c,o,s} after op accept
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        ld;
        logic [15:0] tgt;
        logic [2:0]  dep;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [5:0] o, input logic [15:0] pc,
                          input logic [3:0] fl, input logic [3:0] fl_late,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic exp_ld, input logic [15:0] exp_pc,
                          input logic [2:0] exp_dep, input string tag);
        op = o;
        pcin = pc;
        {zflag, cflag, oflag, sflag} = fl;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        {zflag, cflag, oflag, sflag} = fl_late;
        check({tag, ".busy_accept"}, 32'(busy), 32'd1);
        if (o[5:4] != 2'b11) begin
            byte_we = 1'b1;
            databus = b0;
            tick();
            databus = b1;
            tick();
            byte_we = 1'b0;
            databus = '0;
        end
        check({tag, ".busy_exec"}, 32'(busy), 32'd1);
        check({tag, ".ld_exec"}, 32'(pc_load), 32'd0);
        tick();
        check({tag, ".pc_load"}, 32'(pc_load), 32'(exp_ld));
        check({tag, ".pc_out"}, 32'(pc_out), exp_ld ? 32'(exp_pc) : 32'd0);
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check({tag, ".depth"}, 32'(depth), 32'(exp_dep));
        tick();
        check({tag, ".ld_after"}, 32'(pc_load), 32'd0);
        check({tag, ".pc_after"}, 32'(pc_out), 32'd0);
    endtask

    initial begin
        //           op     pc        fl    late  b0     b1     ld    tgt        dep
        tbl[0]  = '{6'h00, 16'h0000, 4'h0, 4'h0, 8'h12, 8'h34, 1'b1, 16'h1234, 3'd0};
        tbl[1]  = '{6'h10, 16'hFFF0, 4'h0, 4'h0, 8'h00, 8'h20, 1'b1, 16'h0010, 3'd0};
        tbl[2]  = '{6'h01, 16'h0000, 4'h0, 4'h8, 8'h55, 8'h66, 1'b0, 16'h0000, 3'd0};
        tbl[3]  = '{6'h09, 16'h0000, 4'h0, 4'h0, 8'h56, 8'h78, 1'b1, 16'h5678, 3'd0};
        tbl[4]  = '{6'h20, 16'h0100, 4'h0, 4'h0, 8'h20, 8'h00, 1'b1, 16'h2000, 3'd1};
        tbl[5]  = '{6'h30, 16'h0200, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1, 16'h0100, 3'd0};
        tbl[6]  = '{6'h0B, 16'h0000, 4'hF, 4'hF, 8'h11, 8'h22, 1'b0, 16'h0000, 3'd0};
        tbl[7]  = '{6'h03, 16'h0000, 4'h4, 4'h4, 8'hAB, 8'hCD, 1'b1, 16'hABCD, 3'd0};
        tbl[8]  = '{6'h07, 16'h0000, 4'h2, 4'h2, 8'h01, 8'h02, 1'b1, 16'h0102, 3'd0};
        tbl[9]  = '{6'h0A, 16'h0000, 4'h3, 4'h3, 8'h03, 8'h04, 1'b1, 16'h0304, 3'd0};
        tbl[10] = '{6'h02, 16'h0000, 4'h8, 4'h8, 8'h05, 8'h06, 1'b0, 16'h0000, 3'd0};
        tbl[11] = '{6'h06, 16'h0000, 4'h4, 4'h4, 8'h07, 8'h08, 1'b0, 16'h0000, 3'd0};
        tbl[12] = '{6'h04, 16'h0000, 4'h8, 4'h8, 8'h09, 8'h0A, 1'b1, 16'h090A, 3'd0};
        tbl[13] = '{6'h08, 16'h0000, 4'h8, 4'h8, 8'h0B, 8'h0C, 1'b1, 16'h0B0C, 3'd0};
        tbl[14] = '{6'h11, 16'h1000, 4'h8, 4'h8, 8'h00, 8'h34, 1'b1, 16'h1034, 3'd0};
        tbl[15] = '{6'h05, 16'h0000, 4'h4, 4'h4, 8'h0D, 8'h0E, 1'b0, 16'h0000, 3'd0};
        tbl[16] = '{6'h10, 16'h0100, 4'h0, 4'h0, 8'hFF, 8'hF0, 1'b1, 16'h00F0, 3'd0};

        rst = 1'b1;
        op_valid = 1'b0;
        op = '0;
        databus = '0;
        byte_we = 1'b0;
        pcin = '0;
        {zflag, cflag, oflag, sflag} = 4'h0;
        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.pc_load", 32'(pc_load), 32'd0);
        check("rst.pc_out", 32'(pc_out), 32'd0);
        check("rst.depth", 32'(depth), 32'd0);
        check("rst.ovf", 32'(stk_overflow), 32'd0);
        check("rst.unf", 32'(stk_underflow), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i].op, tbl[i].pc, tbl[i].fl, tbl[i].fl_late, tbl[i].b0, tbl[i].b1,
                   tbl[i].ld, tbl[i].tgt, tbl[i].dep, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.ovf", i), 32'(stk_overflow), 32'd0);
            check($sformatf("vec%0d.unf", i), 32'(stk_underflow), 32'd0);
        end

        // Five calls: the fifth finds the stack full.
        for (int i = 0; i < 5; i++) begin
            run_op(6'h20, 16'h1000 + 16'(i), 4'h0, 4'h0, 8'h0A, 8'(i),
                   (i < 4), 16'h0A00 + 16'(i), (i < 4) ? 3'(i + 1) : 3'd4,
                   $sformatf("call%0d", i));
        end
        check("call.ovf", 32'(stk_overflow), 32'd1);
        check("call.unf", 32'(stk_underflow), 32'd0);

        // Five returns: LIFO order, the fifth finds the stack empty.
        for (int i = 0; i < 5; i++) begin
            run_op(6'h30, 16'h0000, 4'h0, 4'h0, 8'h00, 8'h00,
                   (i < 4), 16'h1003 - 16'(i), (i < 4) ? 3'(3 - i) : 3'd0,
                   $sformatf("ret%0d", i));
        end
        check("ret.unf", 32'(stk_underflow), 32'd1);
        check("ret.ovf_sticky", 32'(stk_overflow), 32'd1);

        // Reset in the middle of byte collection.
        op = 6'h00;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        byte_we = 1'b1;
        databus = 8'hAB;
        tick();
        byte_we = 1'b0;
        check("mid.busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid.busy_async", 32'(busy), 32'd0);
        check("mid.ovf_clr", 32'(stk_overflow), 32'd0);
        check("mid.unf_clr", 32'(stk_underflow), 32'd0);
        tick();
        check("mid.ld_rst", 32'(pc_load), 32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid.ld_idle%0d", i), 32'(pc_load), 32'd0);
            check($sformatf("mid.busy_idle%0d", i), 32'(busy), 32'd0);
        end
        run_op(6'h00, 16'h0000, 4'h0, 4'h0, 8'h9A, 8'hBC, 1'b1, 16'h9ABC, 3'd0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
